// File: rtl/alu_share_arb.sv
// alu_share_arb
//   Shares one combinational ALU between two requesters. A round-robin
//   arbiter picks a requester in IDLE, the latched operation is presented
//   to the ALU for one EXEC cycle, and the captured result/flags are held
//   in RESP until the granted requester takes the response.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   reqN_valid_i/reqN_ready_o    request handshake (N = 0, 1)
//   reqN_op_i, reqN_a_i, reqN_b_i   opcode and operands of requester N
//   rspN_valid_o/rspN_ready_i    response handshake (N = 0, 1)
//   rsp_result_o, rsp_flag_o     captured ALU result and {C,O,S,Z}
//   alu_cntrl_o, alu_a_o, alu_b_o   drive the shared ALU
//   alu_result_i, alu_flag_i     ALU outputs
//   grant_o                      requester currently being served
//   busy_o                       FSM not in IDLE
//   cnt0_o, cnt1_o               completed responses per requester (wrap)
`timescale 1ns/1ps
module alu_share_arb #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [3:0]       req0_op_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [3:0]       req1_op_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic [3:0]       rsp_flag_o,
  output logic [3:0]       alu_cntrl_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic [3:0]       alu_flag_i,
  output logic             grant_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt0_o,
  output logic [CNT_W-1:0] cnt1_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  logic             last_q;
  logic             grant_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       flag_q;
  logic [1:0]       rsp_vld_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  logic sel_d;
  logic accept_d;
  logic rsp_hs_d;

  // On a tie the requester that was not served last wins; otherwise the
  // only valid requester is picked. Ready is gated by rst_i so it reads 0
  // while reset is held, even though the FSM already sits in IDLE.
  always_comb begin
    sel_d    = (req0_valid_i && req1_valid_i) ? ~last_q : req1_valid_i;
    accept_d = rst_i && (state_q == IDLE) && (req0_valid_i || req1_valid_i);
    rsp_hs_d = (rsp_vld_q[0] && rsp0_ready_i) || (rsp_vld_q[1] && rsp1_ready_i);
  end

  assign req0_ready_o = accept_d && !sel_d;
  assign req1_ready_o = accept_d && sel_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      flag_q    <= '0;
      rsp_vld_q <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            grant_q <= sel_d;
            op_q    <= sel_d ? req1_op_i : req0_op_i;
            a_q     <= sel_d ? req1_a_i  : req0_a_i;
            b_q     <= sel_d ? req1_b_i  : req0_b_i;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q     <= alu_result_i;
          flag_q    <= alu_flag_i;
          rsp_vld_q <= grant_q ? 2'b10 : 2'b01;
          state_q   <= RESP;
        end
        RESP: begin
          if (rsp_hs_d) begin
            rsp_vld_q <= 2'b00;
            last_q    <= grant_q;
            if (grant_q) cnt1_q <= cnt1_q + CNT_W'(1);
            else         cnt0_q <= cnt0_q + CNT_W'(1);
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The ALU sees the latched operation for the whole EXEC cycle; the
  // registers are only reloaded on the next accept.
  assign alu_cntrl_o  = op_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign rsp0_valid_o = rsp_vld_q[0];
  assign rsp1_valid_o = rsp_vld_q[1];
  assign rsp_result_o = res_q;
  assign rsp_flag_o   = flag_q;
  assign grant_o      = grant_q;
  assign busy_o       = (state_q != IDLE);
  assign cnt0_o       = cnt0_q;
  assign cnt1_o       = cnt1_q;

endmodule

// File: tb/tb_alu_share_arb.sv
`timescale 1ns/1ps
module tb_alu_share_arb;
  localparam int W  = 24;
  localparam int CW = 8;

  logic          clk;
  logic          rst_i;
  logic          req0_valid_i, req1_valid_i;
  logic          req0_ready_o, req1_ready_o;
  logic [3:0]    req0_op_i, req1_op_i;
  logic [W-1:0]  req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic          rsp0_valid_o, rsp1_valid_o;
  logic          rsp0_ready_i, rsp1_ready_i;
  logic [W-1:0]  rsp_result_o;
  logic [3:0]    rsp_flag_o;
  logic [3:0]    alu_cntrl_o;
  logic [W-1:0]  alu_a_o, alu_b_o;
  logic [W-1:0]  alu_result_i;
  logic [3:0]    alu_flag_i;
  logic          grant_o, busy_o;
  logic [CW-1:0] cnt0_o, cnt1_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [W+3:0] q0[$];
  logic [W+3:0] q1[$];
  int           order[$];
  int           hs_cyc[$];

  alu_share_arb #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_op_i(req0_op_i), .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_op_i(req1_op_i), .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_flag_o(rsp_flag_o),
    .alu_cntrl_o(alu_cntrl_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .alu_flag_i(alu_flag_i),
    .grant_o(grant_o), .busy_o(busy_o),
    .cnt0_o(cnt0_o), .cnt1_o(cnt1_o)
  );

  // Behavioural stand-in for the attached ALU: {C,O,S,Z, result}.
  function automatic logic [W+3:0] alu_model(input logic [3:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W:0]   ext;
    logic [W-1:0] r;
    case (op)
      4'd0:    ext = {1'b0, a} + {1'b0, b};
      4'd1:    ext = {1'b0, a} - {1'b0, b};
      4'd2:    ext = {1'b0, a & b};
      4'd3:    ext = {1'b0, a | b};
      4'd4:    ext = {1'b0, a ^ b};
      default: ext = '0;
    endcase
    r = ext[W-1:0];
    return {ext[W], ext[W], r[W-1], (r == '0), r};
  endfunction

  always_comb {alu_flag_i, alu_result_i} = alu_model(alu_cntrl_o, alu_a_o, alu_b_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: push at request handshake, pop at response handshake.
  always @(negedge clk) begin
    if (rst_i) begin
      if (req0_valid_i && req0_ready_o) q0.push_back(alu_model(req0_op_i, req0_a_i, req0_b_i));
      if (req1_valid_i && req1_ready_o) q1.push_back(alu_model(req1_op_i, req1_a_i, req1_b_i));
      if (rsp0_valid_o && rsp1_valid_o) begin
        n_cmp++; n_bad++;
        $display("FAIL both_rsp_valid: got rsp0=1 rsp1=1, expected at most one");
      end
      if (rsp0_valid_o && rsp0_ready_i) begin
        n_cmp++;
        if (q0.size() == 0) begin
          n_bad++; $display("FAIL rsp0_unexpected: got %h, expected no response", {rsp_flag_o, rsp_result_o});
        end else begin
          logic [W+3:0] e;
          e = q0.pop_front();
          if ({rsp_flag_o, rsp_result_o} !== e) begin
            n_bad++; $display("FAIL rsp0_data: got %h, expected %h", {rsp_flag_o, rsp_result_o}, e);
          end
        end
        order.push_back(0); hs_cyc.push_back(cyc);
      end
      if (rsp1_valid_o && rsp1_ready_i) begin
        n_cmp++;
        if (q1.size() == 0) begin
          n_bad++; $display("FAIL rsp1_unexpected: got %h, expected no response", {rsp_flag_o, rsp_result_o});
        end else begin
          logic [W+3:0] e;
          e = q1.pop_front();
          if ({rsp_flag_o, rsp_result_o} !== e) begin
            n_bad++; $display("FAIL rsp1_data: got %h, expected %h", {rsp_flag_o, rsp_result_o}, e);
          end
        end
        order.push_back(1); hs_cyc.push_back(cyc);
      end
    end
  end

  // Drives one request and returns just after the accepting edge (DUT in EXEC).
  task automatic issue(input bit n, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (n) begin req1_valid_i = 1'b1; req1_op_i = op; req1_a_i = a; req1_b_i = b; end
    else   begin req0_valid_i = 1'b1; req0_op_i = op; req0_a_i = a; req0_b_i = b; end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = n ? req1_ready_o : req0_ready_o;
    end
    @(posedge clk); #1;
    // Scramble the payload after the handshake; it must not matter.
    if (n) begin req1_valid_i = 1'b0; req1_a_i = ~a; req1_op_i = ~op; end
    else   begin req0_valid_i = 1'b0; req0_a_i = ~a; req0_op_i = ~op; end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: requester %0d got no ready, expected ready within 60 cycles", n);
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      idle = !busy_o;
    end
    if (!idle) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: busy_o stuck at 1, expected 0 within 60 cycles");
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({req0_ready_o, req1_ready_o} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b, expected 00", {req0_ready_o, req1_ready_o}); end
    n_cmp++; if ({rsp0_valid_o, rsp1_valid_o, busy_o, grant_o} !== 4'b0000) begin n_bad++; $display("FAIL reset_ctrl: got %b, expected 0000", {rsp0_valid_o, rsp1_valid_o, busy_o, grant_o}); end
    n_cmp++; if ({rsp_result_o, rsp_flag_o} !== '0) begin n_bad++; $display("FAIL reset_rsp: got %h, expected 0", {rsp_result_o, rsp_flag_o}); end
    n_cmp++; if ({alu_cntrl_o, alu_a_o, alu_b_o, cnt0_o, cnt1_o} !== '0) begin n_bad++; $display("FAIL reset_alu_cnt: got %h, expected 0", {alu_cntrl_o, alu_a_o, alu_b_o, cnt0_o, cnt1_o}); end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    rst_i = 1'b1;
  endtask

  task automatic test_tie();
    fork
      issue(1'b0, 4'd1, 24'd2, 24'd3);
      issue(1'b1, 4'd15, 24'h00ABCD, 24'h001234);
      begin
        bit s0, s1;
        s0 = 1'b0; s1 = 1'b0;
        for (int i = 0; i < 40 && !s1; i++) begin
          @(negedge clk);
          if (rsp0_valid_o && !s0) begin
            s0 = 1'b1;
            n_cmp++; if (rsp_result_o !== 24'hFFFFFF) begin n_bad++; $display("FAIL tie_sub_result: got %h, expected ffffff", rsp_result_o); end
            n_cmp++; if (rsp_flag_o !== 4'b1110) begin n_bad++; $display("FAIL tie_sub_flag: got %b, expected 1110", rsp_flag_o); end
          end
          if (rsp1_valid_o && !s1) begin
            s1 = 1'b1;
            n_cmp++; if (s0 !== 1'b1) begin n_bad++; $display("FAIL tie_order: req1 served before req0, expected req0 first"); end
            n_cmp++; if ({rsp_flag_o, rsp_result_o} !== {4'b0001, 24'h000000}) begin n_bad++; $display("FAIL tie_op15: got %h, expected 1000000", {rsp_flag_o, rsp_result_o}); end
          end
        end
        if (!s1) begin n_cmp++; n_bad++; $display("FAIL tie_timeout: got no rsp1, expected one"); end
      end
    join
    wait_idle();
    n_cmp++; if ({cnt0_o, cnt1_o} !== {8'd1, 8'd1}) begin n_bad++; $display("FAIL tie_cnt: got %0d/%0d, expected 1/1", cnt0_o, cnt1_o); end
  endtask

  task automatic test_single_add();
    issue(1'b0, 4'd0, 24'd5, 24'd3);
    @(negedge clk);
    n_cmp++; if ({rsp0_valid_o, busy_o, grant_o} !== 3'b010) begin n_bad++; $display("FAIL add_exec: got valid/busy/grant %b, expected 010", {rsp0_valid_o, busy_o, grant_o}); end
    @(negedge clk);
    n_cmp++; if ({rsp0_valid_o, rsp1_valid_o} !== 2'b10) begin n_bad++; $display("FAIL add_rsp_valid: got %b, expected 10", {rsp0_valid_o, rsp1_valid_o}); end
    n_cmp++; if ({rsp_flag_o, rsp_result_o} !== {4'b0000, 24'h000008}) begin n_bad++; $display("FAIL add_result: got %h, expected 0000008", {rsp_flag_o, rsp_result_o}); end
    @(negedge clk);
    n_cmp++; if ({busy_o, rsp0_valid_o} !== 2'b00) begin n_bad++; $display("FAIL add_done: got busy/valid %b, expected 00", {busy_o, rsp0_valid_o}); end
    n_cmp++; if (cnt0_o !== 8'd2) begin n_bad++; $display("FAIL add_cnt0: got %0d, expected 2", cnt0_o); end
  endtask

  task automatic test_contention();
    logic [3:0] ops [6];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd15};
    order.delete(); hs_cyc.delete();
    fork
      for (int i = 0; i < 5; i++) issue(1'b0, ops[$urandom_range(5)], W'($urandom), W'($urandom));
      for (int j = 0; j < 5; j++) issue(1'b1, ops[$urandom_range(5)], W'($urandom), W'($urandom));
    join
    wait_idle();
    n_cmp++;
    if (order.size() != 10) begin n_bad++; $display("FAIL cont_count: got %0d responses, expected 10", order.size()); end
    else begin
      for (int k = 1; k < 10; k++) begin
        n_cmp++; if (order[k] == order[k-1]) begin n_bad++; $display("FAIL cont_alternate: got grant %0d twice at %0d, expected alternation", order[k], k); end
        n_cmp++; if (hs_cyc[k] - hs_cyc[k-1] != 3) begin n_bad++; $display("FAIL cont_spacing: got %0d cycles, expected 3", hs_cyc[k] - hs_cyc[k-1]); end
      end
    end
    n_cmp++; if ({cnt0_o, cnt1_o} !== {8'd7, 8'd6}) begin n_bad++; $display("FAIL cont_cnt: got %0d/%0d, expected 7/6", cnt0_o, cnt1_o); end
  endtask

  task automatic test_back_pressure();
    rsp0_ready_i = 1'b0;
    issue(1'b0, 4'd0, 24'h123456, 24'h111111);
    fork
      issue(1'b1, 4'd0, 24'h000100, 24'h000200);
      begin
        logic [W-1:0] held;
        @(negedge clk);
        @(negedge clk);
        held = rsp_result_o;
        n_cmp++; if (held !== 24'h234567) begin n_bad++; $display("FAIL bp_result: got %h, expected 234567", held); end
        repeat (6) begin
          @(negedge clk);
          n_cmp++;
          if ({rsp0_valid_o, busy_o, req1_ready_o} !== 3'b110 || rsp_result_o !== held) begin
            n_bad++; $display("FAIL bp_hold: got valid/busy/ready1 %b result %h, expected 110 result %h", {rsp0_valid_o, busy_o, req1_ready_o}, rsp_result_o, held);
          end
        end
        @(posedge clk); #1;
        rsp0_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({req1_ready_o, rsp0_valid_o} !== 2'b10) begin n_bad++; $display("FAIL bp_req1_accept: got ready1/rsp0 %b, expected 10", {req1_ready_o, rsp0_valid_o}); end
      end
    join
    wait_idle();
    n_cmp++; if ({cnt0_o, cnt1_o} !== {8'd8, 8'd7}) begin n_bad++; $display("FAIL bp_cnt: got %0d/%0d, expected 8/7", cnt0_o, cnt1_o); end
  endtask

  task automatic test_reset_mid_exec();
    issue(1'b1, 4'd4, 24'h00F0F0, 24'h0F0F0F);
    #2;
    rst_i = 1'b0;
    req0_valid_i = 1'b1;
    #1;
    n_cmp++; if ({req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o} !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_hs: got %b, expected 0000", {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o}); end
    n_cmp++; if ({grant_o, busy_o} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_ctrl: got grant/busy %b, expected 00", {grant_o, busy_o}); end
    n_cmp++; if ({rsp_result_o, rsp_flag_o} !== '0) begin n_bad++; $display("FAIL rst_mid_rsp: got %h, expected 0", {rsp_result_o, rsp_flag_o}); end
    n_cmp++; if ({alu_cntrl_o, alu_a_o, alu_b_o} !== '0) begin n_bad++; $display("FAIL rst_mid_alu: got %h, expected 0", {alu_cntrl_o, alu_a_o, alu_b_o}); end
    n_cmp++; if ({cnt0_o, cnt1_o} !== '0) begin n_bad++; $display("FAIL rst_mid_cnt: got %0d/%0d, expected 0/0", cnt0_o, cnt1_o); end
    q0.delete(); q1.delete();
    req0_valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_cmp++; if ({rsp0_valid_o, rsp1_valid_o, busy_o} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_ghost: got %b, expected 000", {rsp0_valid_o, rsp1_valid_o, busy_o}); end
    end
    issue(1'b0, 4'd0, 24'd7, 24'd9);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({rsp0_valid_o, rsp_result_o} !== {1'b1, 24'd16}) begin n_bad++; $display("FAIL rst_mid_after: got %b %h, expected 1 000010", rsp0_valid_o, rsp_result_o); end
    wait_idle();
    n_cmp++; if (cnt0_o !== 8'd1) begin n_bad++; $display("FAIL rst_mid_cnt0: got %0d, expected 1", cnt0_o); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 254; i++) issue(1'b0, 4'($urandom_range(15)), W'($urandom), W'($urandom));
    wait_idle();
    n_cmp++; if (cnt0_o !== 8'd255) begin n_bad++; $display("FAIL wrap_255: got %0d, expected 255", cnt0_o); end
    issue(1'b0, 4'd2, 24'hFFFFFF, 24'h00FF00);
    wait_idle();
    n_cmp++; if (cnt0_o !== 8'd0) begin n_bad++; $display("FAIL wrap_0: got %0d, expected 0", cnt0_o); end
  endtask

  initial begin
    rst_i = 1'b0;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_op_i = '0; req0_a_i = '0; req0_b_i = '0;
    req1_op_i = '0; req1_a_i = '0; req1_b_i = '0;
    rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    test_reset();
    test_tie();
    test_single_add();
    test_contention();
    test_back_pressure();
    test_reset_mid_exec();
    test_wrap();
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++; $display("FAIL leftover: got %0d/%0d pending responses, expected 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
